// File: rtl/irq_pending_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// irq_pending_ctrl_pkg
// Shared definitions for the interrupt pending controller:
//   IRQ_W / IRQ_CODE_W : number of request sources and width of their index
//   ST_IDLE / ST_PRESENT : handshake FSM encodings
//   msb_index()         : index of the most significant set bit (bit 7 wins)
// ---------------------------------------------------------------------------
package irq_pending_ctrl_pkg;

  localparam int IRQ_W      = 8;
  localparam int IRQ_CODE_W = 3;

  localparam logic ST_IDLE    = 1'b0;
  localparam logic ST_PRESENT = 1'b1;

  // Returns the index of the highest set bit; 0 for an all-zero vector.
  // The ascending scan lets later (higher) bits overwrite lower ones.
  function automatic logic [IRQ_CODE_W-1:0] msb_index(input logic [IRQ_W-1:0] vec);
    logic [IRQ_CODE_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < IRQ_W; i++) begin
      if (vec[i]) idx = IRQ_CODE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// ---------------------------------------------------------------------------
// irq_sync_edge
// Brings IRQ_W asynchronous request lines into the clk domain through a
// SYNC_STAGES-deep flop chain and produces one set pulse per line.
//   clk, rst_n : clock, asynchronous active-low reset
//   req_in     : raw asynchronous requests
//   set_o      : EDGE_MODE=1 -> high for one cycle after a 0->1 transition
//                of the synchronised request; EDGE_MODE=0 -> synchronised level
// ---------------------------------------------------------------------------
module irq_sync_edge
  import irq_pending_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IRQ_W-1:0] req_in,
  output logic [IRQ_W-1:0] set_o
);

  // Forcing the previous-sample term to 0 in level mode keeps one datapath
  // for both modes.
  localparam logic EDGE_BIT = (EDGE_MODE != 0);

  logic [SYNC_STAGES-1:0][IRQ_W-1:0] sync_q, sync_d;
  logic [IRQ_W-1:0]                  req_q, req_d;
  logic [IRQ_W-1:0]                  req_s;

  always_comb begin
    sync_d[0] = req_in;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];
  assign req_d = req_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      req_q  <= '0;
    end else begin
      sync_q <= sync_d;
      req_q  <= req_d;
    end
  end

  for (genvar gi = 0; gi < IRQ_W; gi++) begin : g_set
    assign set_o[gi] = req_s[gi] & ~(req_q[gi] & EDGE_BIT);
  end

endmodule

// File: rtl/irq_pending_ctrl.sv
// ---------------------------------------------------------------------------
// irq_pending_ctrl
// Latches synchronised interrupt requests as pending bits and presents the
// highest-priority unmasked one as a registered code over valid/ready.
//   clk, rst_n : clock, asynchronous active-low reset
//   req_in     : raw asynchronous requests, bit 7 highest priority
//   mask       : 1 = source masked (still goes pending, never presented)
//   irq_ready  : consumer accepts the presented code
//   ovr_clr    : per-bit synchronous clear of the sticky overrun flags
//   irq_valid  : registered, irq_code is valid
//   irq_code   : registered index of the presented source
//   pending_o  : pending register
//   overrun_o  : sticky overrun flags (request re-fired while still pending)
// ---------------------------------------------------------------------------
module irq_pending_ctrl
  import irq_pending_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IRQ_W-1:0]      req_in,
  input  logic [IRQ_W-1:0]      mask,
  input  logic                  irq_ready,
  input  logic [IRQ_W-1:0]      ovr_clr,
  output logic                  irq_valid,
  output logic [IRQ_CODE_W-1:0] irq_code,
  output logic [IRQ_W-1:0]      pending_o,
  output logic [IRQ_W-1:0]      overrun_o
);

  localparam logic EDGE_BIT = (EDGE_MODE != 0);

  logic [IRQ_W-1:0]      set_vec;
  logic                  state_q, state_d;
  logic                  irq_valid_q, irq_valid_d;
  logic [IRQ_CODE_W-1:0] irq_code_q, irq_code_d;
  logic [IRQ_W-1:0]      pending_q, pending_d;
  logic [IRQ_W-1:0]      overrun_q, overrun_d;
  logic [IRQ_W-1:0]      clr_vec;
  logic [IRQ_W-1:0]      eligible;
  logic [IRQ_W-1:0]      ovr_set;

  irq_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_MODE   (EDGE_MODE)
  ) u_sync_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_in (req_in),
    .set_o  (set_vec)
  );

  always_comb begin
    clr_vec     = '0;
    eligible    = pending_q & ~mask;
    state_d     = state_q;
    irq_valid_d = irq_valid_q;
    irq_code_d  = irq_code_q;

    if (state_q == ST_PRESENT && irq_ready) begin
      clr_vec = IRQ_W'(1) << irq_code_q;
    end

    // A set landing on the accept edge of the same bit re-arms it; OR-ing
    // set after the clear gives set priority, and excluding clr_vec from the
    // overrun term stops that collision being counted as an overrun.
    pending_d = (pending_q & ~clr_vec) | set_vec;
    ovr_set   = set_vec & pending_q & ~clr_vec & {IRQ_W{EDGE_BIT}};
    overrun_d = (overrun_q & ~ovr_clr) | ovr_set;

    case (state_q)
      ST_IDLE: begin
        if (eligible != '0) begin
          irq_code_d  = msb_index(eligible);
          irq_valid_d = 1'b1;
          state_d     = ST_PRESENT;
        end
      end
      default: begin
        // Code is frozen while presented; only an accept releases it.
        if (irq_ready) begin
          irq_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      irq_valid_q <= 1'b0;
      irq_code_q  <= '0;
      pending_q   <= '0;
      overrun_q   <= '0;
    end else begin
      state_q     <= state_d;
      irq_valid_q <= irq_valid_d;
      irq_code_q  <= irq_code_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
    end
  end

  assign irq_valid = irq_valid_q;
  assign irq_code  = irq_code_q;
  assign pending_o = pending_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// ---------------------------------------------------------------------------
// tb_irq_pending_ctrl
// Directed scenarios plus randomized traffic, checked every cycle against a
// behavioural model: requests travel through a sample-history array, and
// pending/overrun/presentation are updated from the interrupt rules directly.
// ---------------------------------------------------------------------------
module tb_irq_pending_ctrl;

  localparam int S    = 2;
  localparam int EDGE = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_in;
  logic [7:0] mask;
  logic       irq_ready;
  logic [7:0] ovr_clr;
  logic       irq_valid;
  logic [2:0] irq_code;
  logic [7:0] pending_o;
  logic [7:0] overrun_o;

  int checks = 0;
  int errors = 0;

  // model state
  logic [7:0] hist [0:3];   // hist[k] = req_in sampled k+1 edges ago
  logic [7:0] m_pend;
  logic [7:0] m_ovr;
  logic       m_valid;
  logic [2:0] m_code;

  logic [2:0] accepted [$];

  irq_pending_ctrl #(.SYNC_STAGES(S), .EDGE_MODE(EDGE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_in    (req_in),
    .mask      (mask),
    .irq_ready (irq_ready),
    .ovr_clr   (ovr_clr),
    .irq_valid (irq_valid),
    .irq_code  (irq_code),
    .pending_o (pending_o),
    .overrun_o (overrun_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) hist[k] = 8'h00;
    m_pend  = 8'h00;
    m_ovr   = 8'h00;
    m_valid = 1'b0;
    m_code  = 3'd0;
  endtask

  task automatic model_edge();
    logic [7:0] rs, rq, setv, clr, elig, ovr;
    if (!rst_n) begin
      model_reset();
      return;
    end
    rs   = hist[S-1];
    rq   = hist[S];
    setv = (EDGE != 0) ? (rs & ~rq) : rs;
    clr  = 8'h00;
    if (m_valid && irq_ready) clr[m_code] = 1'b1;
    elig = m_pend & ~mask;
    ovr  = (EDGE != 0) ? (setv & m_pend & ~clr) : 8'h00;
    m_ovr  = (m_ovr & ~ovr_clr) | ovr;
    m_pend = (m_pend & ~clr) | setv;
    if (m_valid) begin
      if (irq_ready) m_valid = 1'b0;
    end else if (elig != 8'h00) begin
      for (int i = 0; i < 8; i++) if (elig[i]) m_code = 3'(i);
      m_valid = 1'b1;
    end
    for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = req_in;
  endtask

  task automatic compare();
    chk("irq_valid", {7'd0, irq_valid}, {7'd0, m_valid});
    if (m_valid) chk("irq_code", {5'd0, irq_code}, {5'd0, m_code});
    chk("pending_o", pending_o, m_pend);
    chk("overrun_o", overrun_o, m_ovr);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst_n = 1'b0; req_in = 8'hFF; mask = 8'h00; irq_ready = 1'b0; ovr_clr = 8'h00;
    model_reset();

    // Reset with all requests high
    steps(3);
    chk("reset_valid", {7'd0, irq_valid}, 8'h00);
    chk("reset_pending", pending_o, 8'h00);
    chk("reset_overrun", overrun_o, 8'h00);
    rst_n = 1'b1;
    steps(3);
    chk("rel_pending", pending_o, 8'hFF);
    chk("rel_valid_early", {7'd0, irq_valid}, 8'h00);
    step();
    chk("rel_valid", {7'd0, irq_valid}, 8'h01);
    chk("rel_code", {5'd0, irq_code}, 8'h07);
    req_in = 8'h00; irq_ready = 1'b1;
    steps(20);
    chk("drain_ff", pending_o, 8'h00);

    // Priority and drain: 5, 2, 0
    req_in = 8'h25; step();
    req_in = 8'h00;
    for (int i = 0; i < 12; i++) begin
      step();
      if (irq_valid && irq_ready) accepted.push_back(irq_code);
    end
    chk("acc_count", 8'(accepted.size()), 8'd3);
    if (accepted.size() == 3) begin
      chk("acc0", {5'd0, accepted[0]}, 8'd5);
      chk("acc1", {5'd0, accepted[1]}, 8'd2);
      chk("acc2", {5'd0, accepted[2]}, 8'd0);
    end
    chk("prio_pending", pending_o, 8'h00);

    // Hold stability
    irq_ready = 1'b0;
    req_in = 8'h04; step(); req_in = 8'h00; steps(3);
    chk("hold_code2", {5'd0, irq_code}, 8'd2);
    req_in = 8'h40; step(); req_in = 8'h00; steps(4);
    chk("hold_still2", {5'd0, irq_code}, 8'd2);
    chk("hold_pending", pending_o, 8'h44);
    irq_ready = 1'b1; step(); irq_ready = 1'b0; step();
    chk("hold_next6", {5'd0, irq_code}, 8'd6);
    irq_ready = 1'b1; step(); irq_ready = 1'b0; steps(2);

    // Mask
    mask = 8'h80;
    req_in = 8'h81; step(); req_in = 8'h00; steps(3);
    chk("mask_code0", {5'd0, irq_code}, 8'd0);
    chk("mask_pending", pending_o, 8'h81);
    irq_ready = 1'b1; step(); irq_ready = 1'b0; steps(3);
    chk("mask_idle", {7'd0, irq_valid}, 8'h00);
    chk("mask_kept7", pending_o, 8'h80);
    mask = 8'h00; step();
    chk("unmask_code7", {5'd0, irq_code}, 8'd7);
    irq_ready = 1'b1; step(); irq_ready = 1'b0; step();

    // Overrun
    req_in = 8'h08; step(); req_in = 8'h00; step();
    req_in = 8'h08; step(); req_in = 8'h00; steps(3);
    chk("ovr_set", overrun_o, 8'h08);
    ovr_clr = 8'h08; step(); ovr_clr = 8'h00;
    chk("ovr_clr", overrun_o, 8'h00);

    // Set edge coinciding with accept of bit 3
    req_in = 8'h08; step(); req_in = 8'h00; step();
    irq_ready = 1'b1; step(); irq_ready = 1'b0;
    chk("coll_pending", pending_o, 8'h08);
    chk("coll_overrun", overrun_o, 8'h00);
    step();
    chk("coll_repres", {5'd0, irq_code}, 8'd3);
    irq_ready = 1'b1; step(); irq_ready = 1'b0; steps(2);

    // Asynchronous reset while presenting
    req_in = 8'h10; step(); req_in = 8'h00; steps(3);
    chk("ar_valid_before", {7'd0, irq_valid}, 8'h01);
    irq_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid_drop", {7'd0, irq_valid}, 8'h00);
    chk("ar_pending", pending_o, 8'h00);
    model_reset();
    irq_ready = 1'b0;
    steps(2);
    rst_n = 1'b1;
    steps(3);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      req_in    = 8'($urandom) & 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 15) == 0) mask = 8'($urandom) & 8'($urandom);
      irq_ready = ($urandom_range(0, 2) != 0);
      ovr_clr   = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
